mash_noise_canceller: RTL

Error-cancellation network for the MASH 1-1-1 sigma-delta DAC. It sits directly downstream of the `TRUNCATOR` stages and consumes one carry bit per stage per sample. It recombines them as y = c1 + (1−z⁻¹)·c2 + (1−z⁻¹)²·c3 into a registered multi-level code. The code is emitted as signed value, offset level, and thermometer vector for the unit-element output DAC.

---
 rtl/mash_noise_canceller.sv | 113 +++++++++++
 1 files changed

// File: rtl/mash_noise_canceller.sv
// MASH error-cancellation network: recombines per-stage carries into a registered
// signed code, offset level and thermometer vector. Define MASH_STAGE3_EN for 1-1-1.
module mash_noise_canceller (
   input  logic       clck,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       c1_in,
   input  logic       c2_in,
   input  logic       c3_in,
   output logic [3:0] y_out,
   output logic [2:0] lvl_out,
   output logic [6:0] therm_out,
   output logic       out_valid
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PRIMING = 2'd1,
      PRIMED  = 2'd2
   } prime_e;

   prime_e      prime_q, prime_d;
   logic        c2_d1_q, c2_d1_d;
   logic [3:0]  y_q, y_d;
   logic [2:0]  lvl_q, lvl_d;
   logic [6:0]  therm_q, therm_d;
   logic        vld_q, vld_d;

   logic signed [4:0] d2, d3, sum;
   logic [2:0]        lvl_nxt;
   logic              primed;

`ifdef MASH_STAGE3_EN
   logic c3_d1_q, c3_d1_d, c3_d2_q, c3_d2_d;
`else
   logic unused_c3;
   assign unused_c3 = c3_in;
`endif

   always_comb begin
      c2_d1_d = c2_d1_q;
      prime_d = prime_q;
      y_d     = y_q;
      lvl_d   = lvl_q;
      therm_d = therm_q;
      vld_d   = 1'b0;

      d2 = {4'b0, c2_in} - {4'b0, c2_d1_q};
`ifdef MASH_STAGE3_EN
      c3_d1_d = c3_d1_q;
      c3_d2_d = c3_d2_q;
      d3      = {4'b0, c3_in} - {3'b0, c3_d1_q, 1'b0} + {4'b0, c3_d2_q};
      primed  = (prime_q == PRIMED);
`else
      d3      = '0;
      primed  = (prime_q != EMPTY);
`endif
      sum     = {4'b0, c1_in} + d2 + d3;
      lvl_nxt = 3'(sum + 5'sd3);

      if (in_valid) begin
         c2_d1_d = c2_in;
`ifdef MASH_STAGE3_EN
         c3_d2_d = c3_d1_q;
         c3_d1_d = c3_in;
`endif
         y_d   = 4'(sum);
         lvl_d = lvl_nxt;
         for (int unsigned i = 0; i < 7; i++) begin
            therm_d[i] = (i < {29'b0, lvl_nxt});
         end
         vld_d = primed;
         // Saturating count of accepted samples; idle cycles leave it untouched.
         unique case (prime_q)
            EMPTY:   prime_d = PRIMING;
            PRIMING: prime_d = PRIMED;
            default: prime_d = PRIMED;
         endcase
      end
   end

   always_ff @(posedge clck) begin
      if (!rst) begin
         c2_d1_q <= 1'b0;
`ifdef MASH_STAGE3_EN
         c3_d1_q <= 1'b0;
         c3_d2_q <= 1'b0;
`endif
         prime_q <= EMPTY;
         y_q     <= '0;
         lvl_q   <= '0;
         therm_q <= '0;
         vld_q   <= 1'b0;
      end else begin
         c2_d1_q <= c2_d1_d;
`ifdef MASH_STAGE3_EN
         c3_d1_q <= c3_d1_d;
         c3_d2_q <= c3_d2_d;
`endif
         prime_q <= prime_d;
         y_q     <= y_d;
         lvl_q   <= lvl_d;
         therm_q <= therm_d;
         vld_q   <= vld_d;
      end
   end

   assign y_out     = y_q;
   assign lvl_out   = lvl_q;
   assign therm_out = therm_q;
   assign out_valid = vld_q;

endmodule
